// File: rtl/psram_arbiter_2port.sv
// Two-requester arbiter in front of a single PSRAM controller: one transaction in flight,
// latched command fields, ready-handshake tracking and a per-transaction timeout.
module psram_arbiter_2port #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk_mem,
    input  logic        rst,
    input  logic [23:0] p0_a,
    input  logic [31:0] p0_d,
    input  logic        p0_we,
    input  logic        p0_rd,
    output logic [31:0] p0_spo,
    output logic        p0_ack,
    input  logic [23:0] p1_a,
    input  logic [31:0] p1_d,
    input  logic        p1_we,
    input  logic        p1_rd,
    output logic [31:0] p1_spo,
    output logic        p1_ack,
    output logic [23:0] m_a,
    output logic [31:0] m_d,
    output logic        m_we,
    output logic        m_rd,
    input  logic [31:0] m_spo,
    input  logic        m_ready,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_ACK
    } state_t;

    localparam logic [9:0]  TIMEOUT_CNT  = 10'(TIMEOUT);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t      state_q, state_d;
    logic        gnt_port_q, gnt_port_d;
    logic        gnt_wr_q, gnt_wr_d;
    logic        last_grant_q, last_grant_d;
    logic [23:0] m_a_q, m_a_d;
    logic [31:0] m_d_q, m_d_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] p0_spo_q, p0_spo_d;
    logic [31:0] p1_spo_q, p1_spo_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic        m_we_q, m_we_d;
    logic        m_rd_q, m_rd_d;
    logic        busy_q, busy_d;

    logic        req0, req1, grant_p1, done, expired;
    logic [31:0] rd_data;

    assign req0 = p0_we | p0_rd;
    assign req1 = p1_we | p1_rd;
    // Port 1 wins when it is alone, or under round-robin when port 0 had the last grant.
    assign grant_p1 = req1 && (!req0 || (FIXED_PRIO == 0 && !last_grant_q));

    always_comb begin
        state_d       = state_q;
        gnt_port_d    = gnt_port_q;
        gnt_wr_d      = gnt_wr_q;
        last_grant_d  = last_grant_q;
        m_a_d         = m_a_q;
        m_d_d         = m_d_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        p0_spo_d      = p0_spo_q;
        p1_spo_d      = p1_spo_q;
        p0_ack_d      = 1'b0;
        p1_ack_d      = 1'b0;
        m_we_d        = 1'b0;
        m_rd_d        = 1'b0;
        done          = 1'b0;
        expired       = 1'b0;
        rd_data       = m_spo;

        case (state_q)
            S_IDLE: begin
                if (m_ready && (req0 || req1)) begin
                    state_d      = S_ISSUE;
                    gnt_port_d   = grant_p1;
                    last_grant_d = grant_p1;
                    gnt_wr_d     = grant_p1 ? p1_we : p0_we;
                    m_a_d        = grant_p1 ? p1_a : p0_a;
                    m_d_d        = grant_p1 ? p1_d : p0_d;
                    cnt_d        = 10'd0;
                    m_we_d       = grant_p1 ? p1_we : p0_we;
                    m_rd_d       = grant_p1 ? !p1_we : !p0_we;
                end
            end
            S_ISSUE: state_d = S_WAIT_LOW;
            S_WAIT_LOW: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == TIMEOUT_CNT) begin
                    done    = 1'b1;
                    expired = 1'b1;
                end else if (!m_ready) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = cnt_q + 10'd1;
                if (m_ready) begin
                    done = 1'b1;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    done    = 1'b1;
                    expired = 1'b1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            state_d = S_ACK;
            rd_data = expired ? TIMEOUT_DATA : m_spo;
            if (gnt_port_q) begin
                p1_ack_d = 1'b1;
                if (!gnt_wr_q) p1_spo_d = rd_data;
            end else begin
                p0_ack_d = 1'b1;
                if (!gnt_wr_q) p0_spo_d = rd_data;
            end
            if (expired) timeout_err_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_mem) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gnt_port_q    <= 1'b0;
            gnt_wr_q      <= 1'b0;
            last_grant_q  <= 1'b1;
            m_a_q         <= 24'd0;
            m_d_q         <= 32'd0;
            cnt_q         <= 10'd0;
            timeout_err_q <= 1'b0;
            p0_spo_q      <= 32'd0;
            p1_spo_q      <= 32'd0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            m_we_q        <= 1'b0;
            m_rd_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_port_q    <= gnt_port_d;
            gnt_wr_q      <= gnt_wr_d;
            last_grant_q  <= last_grant_d;
            m_a_q         <= m_a_d;
            m_d_q         <= m_d_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            p0_spo_q      <= p0_spo_d;
            p1_spo_q      <= p1_spo_d;
            p0_ack_q      <= p0_ack_d;
            p1_ack_q      <= p1_ack_d;
            m_we_q        <= m_we_d;
            m_rd_q        <= m_rd_d;
            busy_q        <= busy_d;
        end
    end

    assign m_a         = m_a_q;
    assign m_d         = m_d_q;
    assign m_we        = m_we_q;
    assign m_rd        = m_rd_q;
    assign p0_spo      = p0_spo_q;
    assign p1_spo      = p1_spo_q;
    assign p0_ack      = p0_ack_q;
    assign p1_ack      = p1_ack_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_psram_arbiter_2port.sv
// Bench for psram_arbiter_2port: a round-robin instance and a fixed-priority short-timeout
// instance, each behind a small controller model, checked against one expectation queue.
`timescale 1ns/1ps
module tb_psram_arbiter_2port;

    typedef struct {
        int          dut;
        bit          port;
        bit          wr;
        logic [23:0] a;
        logic [31:0] d;
        logic [31:0] spo;
    } exp_t;

    logic        clk_mem = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] p0_a [2];
    logic [23:0] p1_a [2];
    logic [31:0] p0_d [2];
    logic [31:0] p1_d [2];
    logic [31:0] p0_spo [2];
    logic [31:0] p1_spo [2];
    logic        p0_we [2];
    logic        p0_rd [2];
    logic        p1_we [2];
    logic        p1_rd [2];
    logic        p0_ack [2];
    logic        p1_ack [2];
    logic [23:0] m_a [2];
    logic [31:0] m_d [2];
    logic [31:0] m_spo [2];
    logic        m_we [2];
    logic        m_rd [2];
    logic        m_ready [2];
    logic        busy [2];
    logic        timeout_err [2];
    int          lat [2];
    logic        hang [2];
    logic        hold_low [2];
    logic [31:0] rd_val [2];

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    always #5 clk_mem = ~clk_mem;
    always @(posedge clk_mem) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        rdy_q;
        int          busy_cnt;
        logic [31:0] spo_q;
        logic [31:0] model_spo0, model_spo1;
        logic        strobe_prev, ack0_prev, ack1_prev;
        int          n_cmd = 0;
        int          n_ack0 = 0;
        int          n_ack1 = 0;

        psram_arbiter_2port #(.FIXED_PRIO(g), .TIMEOUT(g == 1 ? 15 : 1023)) u_dut (
            .clk_mem(clk_mem), .rst(rst),
            .p0_a(p0_a[g]), .p0_d(p0_d[g]), .p0_we(p0_we[g]), .p0_rd(p0_rd[g]),
            .p0_spo(p0_spo[g]), .p0_ack(p0_ack[g]),
            .p1_a(p1_a[g]), .p1_d(p1_d[g]), .p1_we(p1_we[g]), .p1_rd(p1_rd[g]),
            .p1_spo(p1_spo[g]), .p1_ack(p1_ack[g]),
            .m_a(m_a[g]), .m_d(m_d[g]), .m_we(m_we[g]), .m_rd(m_rd[g]),
            .m_spo(m_spo[g]), .m_ready(m_ready[g]),
            .busy(busy[g]), .timeout_err(timeout_err[g])
        );

        assign m_ready[g] = rdy_q & ~hold_low[g];
        assign m_spo[g]   = spo_q;

        // Controller: drops ready after a strobe, returns it (with read data) after lat cycles.
        always @(posedge clk_mem) begin
            if (rst) begin
                rdy_q    <= 1'b1;
                busy_cnt <= 0;
                spo_q    <= 32'd0;
            end else if (m_we[g] || m_rd[g]) begin
                rdy_q    <= 1'b0;
                busy_cnt <= lat[g];
            end else if (!rdy_q && !hang[g]) begin
                if (busy_cnt <= 1) begin
                    rdy_q <= 1'b1;
                    spo_q <= rd_val[g];
                end
                busy_cnt <= busy_cnt - 1;
            end
        end

        always @(negedge clk_mem) begin
            if (rst) begin
                model_spo0  <= 32'd0;
                model_spo1  <= 32'd0;
                strobe_prev <= 1'b0;
                ack0_prev   <= 1'b0;
                ack1_prev   <= 1'b0;
            end else begin : mon
                exp_t        e;
                logic [31:0] want;
                strobe_prev <= m_we[g] | m_rd[g];
                ack0_prev   <= p0_ack[g];
                ack1_prev   <= p1_ack[g];
                if (p0_ack[g]) n_ack0 <= n_ack0 + 1;
                if (p1_ack[g]) n_ack1 <= n_ack1 + 1;
                if (busy[g] && sb_q.size() > 0 && sb_q[0].dut == g) begin
                    chk("m_a_hold", {8'h0, m_a[g]}, {8'h0, sb_q[0].a});
                    chk("m_d_hold", m_d[g], sb_q[0].d);
                end
                if (m_we[g] || m_rd[g]) begin
                    n_cmd <= n_cmd + 1;
                    chk("strobe_len", {31'b0, strobe_prev}, 32'd0);
                    chk("cmd_rdy", {31'b0, m_ready[g]}, 32'd1);
                    if (sb_q.size() == 0 || sb_q[0].dut != g)
                        chk("cmd_unexp", {30'b0, m_we[g], m_rd[g]}, 32'd0);
                    else begin
                        chk("cmd_op", {30'b0, m_we[g], m_rd[g]}, sb_q[0].wr ? 32'd2 : 32'd1);
                        chk("cmd_a", {8'h0, m_a[g]}, {8'h0, sb_q[0].a});
                        chk("cmd_d", m_d[g], sb_q[0].d);
                    end
                end
                if (p0_ack[g] || p1_ack[g]) begin
                    chk("ack_len", {30'b0, ack1_prev & p1_ack[g], ack0_prev & p0_ack[g]}, 32'd0);
                    if (sb_q.size() == 0 || sb_q[0].dut != g)
                        chk("ack_unexp", {30'b0, p1_ack[g], p0_ack[g]}, 32'd0);
                    else begin
                        e = sb_q.pop_front();
                        chk("ack_port", {30'b0, p1_ack[g], p0_ack[g]}, e.port ? 32'd2 : 32'd1);
                        if (e.port) begin
                            want = e.wr ? model_spo1 : e.spo;
                            chk("p1_spo", p1_spo[g], want);
                            chk("p0_spo_keep", p0_spo[g], model_spo0);
                            model_spo1 <= want;
                        end else begin
                            want = e.wr ? model_spo0 : e.spo;
                            chk("p0_spo", p0_spo[g], want);
                            chk("p1_spo_keep", p1_spo[g], model_spo1);
                            model_spo0 <= want;
                        end
                    end
                end
            end
        end
    end

    function automatic void push(input int g, input bit port, input bit wr,
                                 input logic [23:0] a, input logic [31:0] d, input logic [31:0] spo);
        exp_t e;
        e.dut = g; e.port = port; e.wr = wr; e.a = a; e.d = d; e.spo = spo;
        sb_q.push_back(e);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk_mem);
        #1;
    endtask

    task automatic wait_ack(input int g, input bit port, input int budget, input bit drop, output int at);
        logic seen;
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_mem);
            if (port ? p1_ack[g] : p0_ack[g]) begin
                seen = 1'b1;
                at = cyc_n;
                if (drop) begin
                    if (port) begin p1_we[g] = 1'b0; p1_rd[g] = 1'b0; end
                    else      begin p0_we[g] = 1'b0; p0_rd[g] = 1'b0; end
                end
            end
        end
        chk("ack_wait", {31'b0, port ? p1_ack[g] : p0_ack[g]}, 32'd1);
        @(posedge clk_mem);
        #1;
    endtask

    task automatic wait_cmd(input int g, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk_mem);
            if (m_we[g] || m_rd[g]) at = cyc_n;
        end
        chk("cmd_wait", {31'b0, m_we[g] | m_rd[g]}, 32'd1);
    endtask

    task automatic wait_rdy_low(input int g, input int budget);
        logic low;
        low = 1'b0;
        for (int i = 0; i < budget && !low; i++) begin
            @(negedge clk_mem);
            if (!m_ready[g]) low = 1'b1;
        end
        chk("rdy_low", {31'b0, m_ready[g]}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, a0, a1, c0;
        for (int g = 0; g < 2; g++) begin
            p0_a[g] = 24'd0; p0_d[g] = 32'd0; p0_we[g] = 1'b0; p0_rd[g] = 1'b0;
            p1_a[g] = 24'd0; p1_d[g] = 32'd0; p1_we[g] = 1'b0; p1_rd[g] = 1'b0;
            lat[g] = 3; hang[g] = 1'b0; hold_low[g] = 1'b0; rd_val[g] = 32'd0;
        end

        rst = 1'b1;
        idle(3);
        @(negedge clk_mem);
        for (int g = 0; g < 2; g++) begin
            chk("rst_m_a", {8'h0, m_a[g]}, 32'd0);
            chk("rst_m_d", m_d[g], 32'd0);
            chk("rst_spo", p0_spo[g] | p1_spo[g], 32'd0);
            chk("rst_ctl", {26'b0, m_we[g], m_rd[g], p0_ack[g], p1_ack[g], busy[g], timeout_err[g]}, 32'd0);
        end
        @(posedge clk_mem); #1;
        rst = 1'b0;

        // First grant must wait for the controller to report ready; then a single read.
        hold_low[0] = 1'b1; lat[0] = 20; rd_val[0] = 32'h1234_5678;
        p0_a[0] = 24'h000100; p0_d[0] = 32'd0; p0_rd[0] = 1'b1;
        push(0, 0, 0, 24'h000100, 32'd0, 32'h1234_5678);
        c0 = g_dut[0].n_cmd;
        idle(6);
        @(negedge clk_mem);
        chk("busy_wait_ready", {31'b0, busy[0]}, 32'd0);
        chk("no_cmd_wait_ready", 32'(g_dut[0].n_cmd - c0), 32'd0);
        hold_low[0] = 1'b0;
        wait_ack(0, 0, 60, 1'b1, t1);
        chk("single_rd_cmds", 32'(g_dut[0].n_cmd - c0), 32'd1);

        // Round-robin contention with both requests already up across reset release.
        rst = 1'b1;
        lat[0] = 3; rd_val[0] = 32'h0BAD_F00D;
        p0_a[0] = 24'h000200; p0_d[0] = 32'hCAFE_0001; p0_we[0] = 1'b1;
        p1_a[0] = 24'h000300; p1_d[0] = 32'd0; p1_rd[0] = 1'b1;
        idle(2);
        rst = 1'b0;
        push(0, 0, 1, 24'h000200, 32'hCAFE_0001, 32'd0);
        push(0, 1, 0, 24'h000300, 32'd0, 32'h0BAD_F00D);
        a0 = g_dut[0].n_ack0; a1 = g_dut[0].n_ack1;
        wait_ack(0, 0, 30, 1'b1, t1);
        wait_ack(0, 1, 30, 1'b1, t1);
        idle(5);
        chk("rr_ack0_cnt", 32'(g_dut[0].n_ack0 - a0), 32'd1);
        chk("rr_ack1_cnt", 32'(g_dut[0].n_ack1 - a1), 32'd1);

        // Second contention round: port 0 next; port 1 raises we+rd together (a write).
        rd_val[0] = 32'h55AA_0000;
        p0_a[0] = 24'h000400; p0_d[0] = 32'h0000_0044; p0_rd[0] = 1'b1;
        p1_a[0] = 24'h000500; p1_d[0] = 32'h5050_5050; p1_we[0] = 1'b1; p1_rd[0] = 1'b1;
        push(0, 0, 0, 24'h000400, 32'h0000_0044, 32'h55AA_0000);
        push(0, 1, 1, 24'h000500, 32'h5050_5050, 32'd0);
        wait_ack(0, 0, 30, 1'b1, t1);
        wait_ack(0, 1, 30, 1'b1, t1);

        // Requester address/data change while the controller is busy.
        lat[0] = 8; rd_val[0] = 32'h600D_0600;
        p0_a[0] = 24'h000600; p0_d[0] = 32'h1111_2222; p0_rd[0] = 1'b1;
        push(0, 0, 0, 24'h000600, 32'h1111_2222, 32'h600D_0600);
        wait_rdy_low(0, 10);
        idle(2);
        p0_a[0] = 24'hFFFFFF; p0_d[0] = 32'hFFFF_FFFF;
        @(negedge clk_mem);
        chk("m_a_after_change", {8'h0, m_a[0]}, 32'h0000_0600);
        chk("m_d_after_change", m_d[0], 32'h1111_2222);
        wait_ack(0, 0, 30, 1'b1, t1);

        // Reset in WAIT_HIGH abandons the transaction silently.
        lat[0] = 10; rd_val[0] = 32'h0000_0077;
        p1_a[0] = 24'h000700; p1_d[0] = 32'd0; p1_rd[0] = 1'b1;
        push(0, 1, 0, 24'h000700, 32'd0, 32'h0000_0077);
        a1 = g_dut[0].n_ack1;
        wait_rdy_low(0, 10);
        idle(3);
        rst = 1'b1; p1_rd[0] = 1'b0;
        sb_q.delete();
        idle(1);
        @(negedge clk_mem);
        chk("midrst_busy", {31'b0, busy[0]}, 32'd0);
        chk("midrst_ack", {30'b0, p0_ack[0], p1_ack[0]}, 32'd0);
        chk("midrst_m_a", {8'h0, m_a[0]}, 32'd0);
        chk("midrst_spo", p0_spo[0] | p1_spo[0], 32'd0);
        @(posedge clk_mem); #1;
        rst = 1'b0;
        idle(12);
        chk("midrst_no_ack", 32'(g_dut[0].n_ack1 - a1), 32'd0);
        lat[0] = 3; rd_val[0] = 32'h0800_0800;
        p1_a[0] = 24'h000800; p1_rd[0] = 1'b1;
        push(0, 1, 0, 24'h000800, 32'd0, 32'h0800_0800);
        wait_ack(0, 1, 30, 1'b1, t1);

        // Fixed priority: port 0 keeps requesting, port 1 waits behind it.
        lat[1] = 4;
        p1_a[1] = 24'h000900; p1_d[1] = 32'h0000_0099; p1_rd[1] = 1'b1;
        p0_d[1] = 32'd0; p0_rd[1] = 1'b1;
        a1 = g_dut[1].n_ack1; c0 = g_dut[1].n_cmd;
        for (int i = 0; i < 4; i++) begin
            rd_val[1] = 32'hF00D_0000 + 32'(i);
            p0_a[1] = 24'h000A00 + 24'(i);
            push(1, 0, 0, p0_a[1], 32'd0, rd_val[1]);
            wait_ack(1, 0, 30, i == 3, t1);
        end
        chk("fp_no_p1", 32'(g_dut[1].n_ack1 - a1), 32'd0);
        chk("fp_p0_cmds", 32'(g_dut[1].n_cmd - c0), 32'd4);

        // Controller never comes back: timeout on port 1.
        hang[1] = 1'b1;
        push(1, 1, 0, 24'h000900, 32'h0000_0099, 32'hDEAD_BEEF);
        wait_cmd(1, 10, t0);
        wait_ack(1, 1, 40, 1'b1, t1);
        chk("to_latency", 32'(t1 - t0), 32'd17);
        chk("to_err", {31'b0, timeout_err[1]}, 32'd1);
        chk("to_err_other", {31'b0, timeout_err[0]}, 32'd0);
        idle(10);
        chk("to_err_sticky", {31'b0, timeout_err[1]}, 32'd1);

        hang[1] = 1'b0; rd_val[1] = 32'h1234_AAAA;
        p0_a[1] = 24'h000B00; p0_d[1] = 32'h0000_B0B0; p0_we[1] = 1'b1;
        push(1, 0, 1, 24'h000B00, 32'h0000_B0B0, 32'd0);
        wait_ack(1, 0, 40, 1'b1, t1);
        chk("to_err_after_ok", {31'b0, timeout_err[1]}, 32'd1);

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk_mem);
        chk("to_err_cleared", {31'b0, timeout_err[1]}, 32'd0);
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
